// File: rtl/sys_ctrl_cmd_if.sv
// Byte and strobe bundle linking the command controller to the UART RX/TX and the register file.
// The master side is the controller; the slave side is the surrounding UART/register-file logic.
interface sys_ctrl_cmd_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [WIDTH-1:0]      RX_P_DATA;
    logic                  RX_D_VLD;
    logic [WIDTH-1:0]      RdData;
    logic                  RdData_Valid;
    logic                  TX_BUSY;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [WIDTH-1:0]      WrData;
    logic [WIDTH-1:0]      TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  CMD_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
        output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
        input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/sys_ctrl_cmd.sv
// Command-frame controller: parses UART write/read frames, drives the register file, returns read bytes to UART TX.
// Optional read timeout in RD_WAIT is compiled in when SYS_CTRL_RD_TIMEOUT_EN is defined.
module sys_ctrl_cmd #(
    parameter int               WIDTH      = 8,
    parameter int               ADDR_WIDTH = 4,
    parameter logic [WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [WIDTH-1:0] RD_CMD     = 8'hBB
) (
    input  logic             CLK,
    input  logic             RST,
    sys_ctrl_cmd_if.master   bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] TX_WAIT = 3'd5;

    logic [2:0]            r_state;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_wr_data;
    logic [WIDTH-1:0]      r_tx_hold;
    logic [WIDTH-1:0]      r_tx_data;
    logic                  r_tx_vld;
    logic                  r_cmd_err;

`ifdef SYS_CTRL_RD_TIMEOUT_EN
    localparam logic [2:0] RD_TMO_LAST = 3'd3;
    logic [2:0]            r_tmo_cnt;
`endif

    logic [ADDR_WIDTH-1:0] w_rx_addr;
    logic                  w_rx_addr_bad;

    // Address bytes carry the register index in the low bits; any high bit set is a malformed frame.
    assign w_rx_addr     = bus.RX_P_DATA[ADDR_WIDTH-1:0];
    assign w_rx_addr_bad = |bus.RX_P_DATA[WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: every holding register is cleared by reset, so an aborted frame leaves no stale address or data.
        if (!RST) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_tx_hold <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;
`ifdef SYS_CTRL_RD_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            // NOTE: strobes default low here with non-blocking assignments; the case arms below win when they pulse.
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.RX_D_VLD) begin
                        if (bus.RX_P_DATA == WR_CMD) begin
                            r_state <= WR_ADDR;
                        end else if (bus.RX_P_DATA == RD_CMD) begin
                            r_state <= RD_ADDR;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end

                WR_ADDR, RD_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        r_addr <= w_rx_addr;
                        if (w_rx_addr_bad) begin
                            r_cmd_err <= 1'b1;
                            r_state   <= IDLE;
                        end else if (r_state == WR_ADDR) begin
                            r_state <= WR_DATA;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_state <= RD_WAIT;
`ifdef SYS_CTRL_RD_TIMEOUT_EN
                            r_tmo_cnt <= '0;
`endif
                        end
                    end
                end

                WR_DATA: begin
                    if (bus.RX_D_VLD) begin
                        r_wr_data <= bus.RX_P_DATA;
                        r_wr_en   <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                RD_WAIT: begin
                    // A byte arriving while a read is in flight is dropped and flagged.
                    if (bus.RX_D_VLD) begin
                        r_cmd_err <= 1'b1;
                    end
`ifdef SYS_CTRL_RD_TIMEOUT_EN
                    if (bus.RdData_Valid) begin
                        r_tx_hold <= bus.RdData;
                        r_state   <= TX_WAIT;
                    end else if (r_tmo_cnt == RD_TMO_LAST) begin
                        r_tx_hold <= {WIDTH{1'b1}};
                        r_cmd_err <= 1'b1;
                        r_state   <= TX_WAIT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 3'd1;
                    end
`else
                    if (bus.RdData_Valid) begin
                        r_tx_hold <= bus.RdData;
                        r_state   <= TX_WAIT;
                    end
`endif
                end

                TX_WAIT: begin
                    if (bus.RX_D_VLD) begin
                        r_cmd_err <= 1'b1;
                    end
                    if (!bus.TX_BUSY) begin
                        r_tx_data <= r_tx_hold;
                        r_tx_vld  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.WrEn      = r_wr_en;
    assign bus.RdEn      = r_rd_en;
    assign bus.Address   = r_addr;
    assign bus.WrData    = r_wr_data;
    assign bus.TX_P_DATA = r_tx_data;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.CMD_ERR   = r_cmd_err;

endmodule
